single_midi_in_rx: RTL and testbench

//  MIDI serial receiver, 8N1 at 31250 baud, running from the system clock.

---
 rtl/midi_pkg.sv | 27 ++
 rtl/midi_bit_timer.sv | 36 +++
 rtl/single_midi_in_rx.sv | 182 ++++++++++++++++++
 tb/tb_single_midi_in_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI receiver: FSM state encoding, default line rate,
// bit-timing helpers and the status-byte mask.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } midi_rx_state_e;

  localparam int MIDI_BAUD_DEFAULT = 31250;
  localparam logic [7:0] MIDI_STATUS_MASK = 8'h80;

  function automatic int clks_per_bit(input int sysclk_f, input int baud);
    return sysclk_f / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/midi_bit_timer.sv
// Bit-period timer for the MIDI receiver: a wrapping clock counter that emits
// a half-bit tick and a full-bit tick, cleared on start-edge detect or re-alignment.
module midi_bit_timer #(
  parameter int CLKS_PER_BIT = 1536,
  parameter int HALF_TICK_AT = 767,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_half_tick,
  output logic o_full_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_TICK_AT);

  logic [CNT_W-1:0] r_cnt;

  // Clock counter: wraps every bit period, restarts on clear
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_half_tick = (r_cnt == HALF_CNT);
  assign o_full_tick = (r_cnt == LAST_CNT);

endmodule

// File: rtl/single_midi_in_rx.sv
// MIDI 8N1 serial receiver: synchronizer, deframing FSM, shift register and output registers.
// Optional `MIDI_RX_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample (+1 cycle latency).
module single_midi_in_rx
  import midi_pkg::*;
#(
  parameter int BYTE_W          = 8,
  parameter int MIDI_BAUD       = MIDI_BAUD_DEFAULT,
  parameter int MIDI_FRAME_SIZE = 10,
  parameter int SYSCLK_F        = 48000000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              MIDI_IN,
  output logic [BYTE_W-1:0] data_rx,
  output logic              is_command,
  output logic              new_byte_strobe
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYSCLK_F, MIDI_BAUD);
  localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_CNT_W    = $clog2(BYTE_W + 1);
  // Data bits are the frame minus start and stop; the counter's last value is one less.
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(MIDI_FRAME_SIZE - 3);
`ifdef MIDI_RX_MAJORITY_EN
  localparam int HALF_TICK_AT = HALF_BIT;
`else
  localparam int HALF_TICK_AT = HALF_BIT - 1;
`endif

  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  logic                 w_rx_s;
  logic                 w_fall;
  logic                 w_sample;
  logic                 w_half_tick;
  logic                 w_full_tick;
  logic                 w_clear;
  logic                 w_shift_en;
  logic                 w_load;
  midi_rx_state_e       r_state;
  midi_rx_state_e       w_state_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BYTE_W-1:0]    r_shift;

  assign w_rx_s = r_sync[1];
  assign w_fall = r_rx_prev & ~w_rx_s;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], MIDI_IN};
      r_rx_prev <= w_rx_s;
    end
  end

`ifdef MIDI_RX_MAJORITY_EN
  logic r_rx_prev2;

  // Second history flop: the vote spans mid-1, mid and mid+1
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_prev2 <= 1'b1;
    end else begin
      r_rx_prev2 <= r_rx_prev;
    end
  end

  assign w_sample = majority3({r_rx_prev2, r_rx_prev, w_rx_s});
`else
  assign w_sample = w_rx_s;
`endif

  midi_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_TICK_AT (HALF_TICK_AT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .o_half_tick (w_half_tick),
    .o_full_tick (w_full_tick)
  );

  // FSM state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_clear     = 1'b1;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        // Re-align the timer to mid-bit so later full ticks land mid data bit
        if (w_half_tick) begin
          w_clear = 1'b1;
          if (!w_sample) begin
            w_state_nxt = DATA;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_full_tick) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST_DATA_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (w_full_tick) begin
          w_load      = w_sample;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Data-bit counter and LSB-first shift register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_clear) begin
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      r_shift   <= {w_sample, r_shift[BYTE_W-1:1]};
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Output registers: only updated by a valid stop bit
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_rx         <= '0;
      is_command      <= 1'b0;
      new_byte_strobe <= 1'b0;
    end else begin
      new_byte_strobe <= w_load;
      if (w_load) begin
        data_rx    <= r_shift;
        is_command <= r_shift[BYTE_W-1];
      end
    end
  end

endmodule

// File: tb/tb_single_midi_in_rx.sv
// Directed bench for single_midi_in_rx: one instance at the native 1536 clk/bit,
// one scaled to 96 clk/bit to keep the frame-heavy tests short.
module tb_single_midi_in_rx;

  localparam int CPB_F    = 1536;
  localparam int HALF_F   = 768;
  localparam int SYSCLK_S = 3000000;
  localparam int CPB_S    = 96;
  localparam int HALF_S   = 48;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line_f, line_s;
  logic [7:0] data_f, data_s;
  logic       cmd_f, cmd_s, stb_f, stb_s;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   sc_f = 0, sc_s = 0, lc_f = 0, lc_s = 0;
  logic prev_f = 1'b0, prev_s = 1'b0;
  int   n0, t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  single_midi_in_rx #(.SYSCLK_F(48000000)) dut_f (
    .sys_clk(clk), .rst_n(rst_n), .MIDI_IN(line_f),
    .data_rx(data_f), .is_command(cmd_f), .new_byte_strobe(stb_f)
  );

  single_midi_in_rx #(.SYSCLK_F(SYSCLK_S)) dut_s (
    .sys_clk(clk), .rst_n(rst_n), .MIDI_IN(line_s),
    .data_rx(data_s), .is_command(cmd_s), .new_byte_strobe(stb_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitors: count pulses, note their cycle, and flag back-to-back pulses
  always @(negedge clk) begin
    if (rst_n && stb_f) begin
      sc_f = sc_f + 1;
      lc_f = cyc;
      check_eq("f_strobe_one_cycle", 32'(prev_f), 32'd0);
    end
    prev_f = stb_f;
  end

  always @(negedge clk) begin
    if (rst_n && stb_s) begin
      sc_s = sc_s + 1;
      lc_s = cyc;
      check_eq("s_strobe_one_cycle", 32'(prev_s), 32'd0);
    end
    prev_s = stb_s;
  end

  // Drives frame[0..nbits-1] for 'period' clocks each; entered and left at posedge+1
  task automatic drive_bits(input logic [9:0] frame, input int period, input int nbits, input bit to_full);
    for (int i = 0; i < nbits; i++) begin
      if (to_full) line_f = frame[i];
      else         line_s = frame[i];
      repeat (period) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int period, input logic stop_bit, input bit to_full);
    drive_bits({stop_bit, b, 1'b0}, period, 10, to_full);
  endtask

  initial begin
    rst_n  = 1'b0;
    line_f = 1'b1;
    line_s = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_data_f", 32'(data_f), 32'h0);
    check_eq("rst_cmd_f",  32'(cmd_f),  32'h0);
    check_eq("rst_stb_f",  32'(stb_f),  32'h0);
    check_eq("rst_data_s", 32'(data_s), 32'h0);
    check_eq("rst_cmd_s",  32'(cmd_s),  32'h0);
    check_eq("rst_stb_s",  32'(stb_s),  32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 1: 0x90 at 1536 clk/bit; strobe lands 2 sync + 1 edge + half + 9 bits + 1 clocks after drive
    n0 = sc_f; t0 = cyc;
    send_byte(8'h90, CPB_F, 1'b1, 1'b1);
    check_eq("t1_count",   32'(sc_f - n0), 32'd1);
    check_eq("t1_data",    32'(data_f), 32'h90);
    check_eq("t1_cmd",     32'(cmd_f), 32'h1);
    check_eq("t1_latency", 32'(lc_f - t0), 32'(3 + HALF_F + 9 * CPB_F));

    // 3: 100-clock low glitch is rejected at the half-bit check
    n0 = sc_f;
    line_f = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    line_f = 1'b1;
    repeat (10 * CPB_F) @(posedge clk);
    #1;
    check_eq("t3_count", 32'(sc_f - n0), 32'd0);
    check_eq("t3_data",  32'(data_f), 32'h90);
    check_eq("t3_cmd",   32'(cmd_f), 32'h1);

    // 2: 0x3C then 0x7F with zero idle between frames
    n0 = sc_s; t0 = cyc;
    send_byte(8'h3C, CPB_S, 1'b1, 1'b0);
    check_eq("t2a_count",   32'(sc_s - n0), 32'd1);
    check_eq("t2a_data",    32'(data_s), 32'h3C);
    check_eq("t2a_cmd",     32'(cmd_s), 32'h0);
    check_eq("t2a_latency", 32'(lc_s - t0), 32'(3 + HALF_S + 9 * CPB_S));
    drive_bits({1'b1, 8'h7F, 1'b0}, CPB_S, 5, 1'b0);
    check_eq("t2_hold_data", 32'(data_s), 32'h3C);
    drive_bits({6'b0, 1'b1, 8'h7F, 1'b0} >> 5, CPB_S, 5, 1'b0);
    check_eq("t2b_count", 32'(sc_s - n0), 32'd2);
    check_eq("t2b_data",  32'(data_s), 32'h7F);
    check_eq("t2b_cmd",   32'(cmd_s), 32'h0);
    repeat (2 * CPB_S) @(posedge clk);
    #1;

    // 4: 0xA5 with a low stop bit is a framing error
    n0 = sc_s;
    send_byte(8'hA5, CPB_S, 1'b0, 1'b0);
    line_s = 1'b1;
    repeat (2 * CPB_S) @(posedge clk);
    #1;
    check_eq("t4_count", 32'(sc_s - n0), 32'd0);
    check_eq("t4_data",  32'(data_s), 32'h7F);
    check_eq("t4_cmd",   32'(cmd_s), 32'h0);

    // 5: reset in the middle of data bit 4 of 0x45, released with the line high
    drive_bits({1'b1, 8'h45, 1'b0}, CPB_S, 5, 1'b0);
    line_s = 1'b0;
    repeat (HALF_S) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    line_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = sc_s;
    repeat (12 * CPB_S) @(posedge clk);
    #1;
    check_eq("t5_abort_count", 32'(sc_s - n0), 32'd0);
    check_eq("t5_abort_data",  32'(data_s), 32'h0);
    check_eq("t5_abort_cmd",   32'(cmd_s), 32'h0);
    send_byte(8'h45, CPB_S, 1'b1, 1'b0);
    check_eq("t5_count", 32'(sc_s - n0), 32'd1);
    check_eq("t5_data",  32'(data_s), 32'h45);
    check_eq("t5_cmd",   32'(cmd_s), 32'h0);
    repeat (2 * CPB_S) @(posedge clk);
    #1;

    // 6: 0x80 at -2% and +2% bit period (94 and 98 against 96 clk/bit)
    n0 = sc_s;
    send_byte(8'h80, 94, 1'b1, 1'b0);
    check_eq("t6_fast_count", 32'(sc_s - n0), 32'd1);
    check_eq("t6_fast_data",  32'(data_s), 32'h80);
    check_eq("t6_fast_cmd",   32'(cmd_s), 32'h1);
    repeat (2 * CPB_S) @(posedge clk);
    #1;
    send_byte(8'h80, 98, 1'b1, 1'b0);
    check_eq("t6_slow_count", 32'(sc_s - n0), 32'd2);
    check_eq("t6_slow_data",  32'(data_s), 32'h80);
    check_eq("t6_slow_cmd",   32'(cmd_s), 32'h1);
    repeat (2 * CPB_S) @(posedge clk);
    #1;
    check_eq("idle_stb_s", 32'(stb_s), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
